// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding, address split constants and write-port byte packing
package cache_pkg;
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} cache_state_t;
  localparam int OFFSET_BITS = 4;
  localparam int WORD_SEL_BITS = 2;
  function automatic logic [127:0] word_swap128(input logic [127:0] d);
    logic [127:0] r;
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 4; k++)
        r[32*w+8*(3-k) +: 8] = d[32*w+8*k +: 8];
    return r;
  endfunction
endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/dirty/tag/data storage with async read and sync line or word writes
module dcache_array #(
  parameter int SETS = 64,
  parameter int TAG_BITS = 22,
  parameter int BLOCK_WIDTH = 128,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [$clog2(SETS)-1:0]   idx,
  input  logic                      line_we,
  input  logic [TAG_BITS-1:0]       line_tag,
  input  logic [BLOCK_WIDTH-1:0]    line_data,
  input  logic                      word_we,
  input  logic [1:0]                word_sel,
  input  logic [DATA_WIDTH/8-1:0]   word_be,
  input  logic [DATA_WIDTH-1:0]     word_data,
  output logic                      valid,
  output logic                      dirty,
  output logic [TAG_BITS-1:0]       tag,
  output logic [BLOCK_WIDTH-1:0]    data
);
  logic [SETS-1:0]        valid_q;
  logic [SETS-1:0]        dirty_q;
  logic [TAG_BITS-1:0]    tag_q  [SETS];
  logic [BLOCK_WIDTH-1:0] data_q [SETS];
  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag   = tag_q[idx];
  assign data  = data_q[idx];
  // line status: refill makes a line valid and clean, a word write dirties it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end
  // tag and data are left unreset; valid guards their use
  always_ff @(posedge clk)
    if (line_we) begin
      tag_q[idx]  <= line_tag;
      data_q[idx] <= line_data;
    end else if (word_we) begin
      for (int k = 0; k < DATA_WIDTH/8; k++)
        if (word_be[k]) data_q[idx][DATA_WIDTH*word_sel+8*k +: 8] <= word_data[8*k +: 8];
    end
endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped write-back write-allocate cache with writeback/refill controller
module data_cache
  import cache_pkg::*;
#(
  parameter int SETS = 64,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic                     cpu_re,
  input  logic                     cpu_we,
  input  logic [DATA_WIDTH/8-1:0]  cpu_be,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     stall,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic                     mem_wr_en,
  output logic [BLOCK_WIDTH-1:0]   mem_wdata,
  input  logic [BLOCK_WIDTH-1:0]   mem_rdata
);
  localparam int INDEX_BITS = $clog2(SETS);
  localparam int TAG_BITS = ADDRESS_WIDTH - INDEX_BITS - OFFSET_BITS;
  cache_state_t state, next;
  logic [INDEX_BITS-1:0]    idx;
  logic [TAG_BITS-1:0]      req_tag, line_tag;
  logic [WORD_SEL_BITS-1:0] word_sel;
  logic [BLOCK_WIDTH-1:0]   line_data;
  logic                     line_valid, line_dirty, hit, req, line_we, word_we;
  assign word_sel = cpu_addr[OFFSET_BITS-1:2];
  assign idx      = cpu_addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign req_tag  = cpu_addr[ADDRESS_WIDTH-1:OFFSET_BITS+INDEX_BITS];
  assign hit      = line_valid && line_tag == req_tag;
  assign req      = cpu_re || cpu_we;
  dcache_array #(
    .SETS(SETS), .TAG_BITS(TAG_BITS), .BLOCK_WIDTH(BLOCK_WIDTH), .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk(clk), .rst_n(rst_n), .idx(idx),
    .line_we(line_we), .line_tag(req_tag), .line_data(mem_rdata),
    .word_we(word_we), .word_sel(word_sel), .word_be(cpu_be), .word_data(cpu_wdata),
    .valid(line_valid), .dirty(line_dirty), .tag(line_tag), .data(line_data)
  );
  // controller state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  // next state, stall and memory-side drive
  always_comb begin
    next      = state;
    stall     = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    mem_addr  = {req_tag, idx, {OFFSET_BITS{1'b0}}};
    cpu_rdata = '0;
    line_we   = 1'b0;
    word_we   = 1'b0;
    case (state)
      IDLE: begin
        stall     = req && !hit;
        next      = !(req && !hit) ? IDLE : (line_valid && line_dirty) ? WRITEBACK : REFILL;
        word_we   = cpu_we && hit;
        cpu_rdata = (cpu_re && hit) ? line_data[DATA_WIDTH*word_sel +: DATA_WIDTH] : '0;
      end
      WRITEBACK: begin
        stall     = 1'b1;
        mem_wr_en = 1'b1;
        mem_addr  = {line_tag, idx, {OFFSET_BITS{1'b0}}};
        mem_wdata = word_swap128(line_data);
        next      = REFILL;
      end
      REFILL: begin
        stall   = 1'b1;
        line_we = 1'b1;
        next    = IDLE;
      end
      default: next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed checks of hits, clean/dirty misses, byte writes and reset mid-refill
module tb_data_cache;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic         cpu_re = 1'b0;
  logic         cpu_we = 1'b0;
  logic [3:0]   cpu_be = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [31:0]  cpu_rdata;
  logic         stall;
  logic [31:0]  mem_addr;
  logic         mem_wr_en;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic [127:0] mem [1024];
  int           total = 0;
  int           bad = 0;
  int           ns;
  logic [31:0]  last_addr, wb_addr, rd;
  logic [127:0] wb_data;
  logic         wb_seen;

  data_cache dut (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we),
    .cpu_be(cpu_be), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[13:4]];

  always @(posedge clk)
    if (mem_wr_en)
      for (int w = 0; w < 4; w++)
        for (int k = 0; k < 4; k++)
          mem[mem_addr[13:4]][32*w+8*k +: 8] <= mem_wdata[32*w+8*(3-k) +: 8];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic access(input logic re, input logic we, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
    cpu_re = re; cpu_we = we; cpu_addr = a; cpu_be = be; cpu_wdata = wd;
    ns = 0; wb_seen = 1'b0; last_addr = '0; wb_addr = '0; wb_data = '0;
    #1;
    while (stall && ns < 10) begin
      ns++;
      last_addr = mem_addr;
      if (mem_wr_en) begin wb_seen = 1'b1; wb_addr = mem_addr; wb_data = mem_wdata; end
      @(posedge clk); #1;
    end
    if (stall) check("stall_timeout", 1, 0);
    rd = cpu_rdata;
  endtask

  task automatic finish_access();
    @(posedge clk); #1;
    cpu_re = 1'b0; cpu_we = 1'b0;
  endtask

  initial begin
    for (int l = 0; l < 1024; l++)
      for (int w = 0; w < 4; w++)
        mem[l][32*w +: 32] = {16'(l), 16'(w)};
    mem[10'h100][31:0] = 32'h11223344;
    #1;
    check("rst_stall", stall, 0);
    check("rst_wr_en", mem_wr_en, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_wdata", mem_wdata, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    access(1, 0, 32'h1000, 4'h0, 0);
    check("miss_stalls", ns, 2);
    check("refill_addr", last_addr, 32'h1000);
    check("miss_rdata", rd, 32'h11223344);
    finish_access();
    access(1, 0, 32'h1004, 4'h0, 0);
    check("hit_stalls", ns, 0);
    check("hit_rdata", rd, 32'h01000001);
    finish_access();

    access(0, 1, 32'h1004, 4'hF, 32'hDEADBEEF);
    check("wr_hit_stalls", ns, 0);
    check("wr_hit_wr_en", mem_wr_en, 0);
    finish_access();
    access(1, 0, 32'h1004, 4'h0, 0);
    check("wr_hit_read", rd, 32'hDEADBEEF);
    finish_access();

    access(0, 1, 32'h1004, 4'b0010, 32'h0000AB00);
    check("byte_wr_stalls", ns, 0);
    finish_access();
    access(1, 0, 32'h1004, 4'h0, 0);
    check("byte_wr_read", rd, 32'hDEADABEF);
    finish_access();

    access(1, 0, 32'h1400, 4'h0, 0);
    check("dirty_stalls", ns, 3);
    check("wb_seen", wb_seen, 1);
    check("wb_addr", wb_addr, 32'h1000);
    check("wb_word1", wb_data[63:32], 32'hEFABADDE);
    check("dirty_refill_addr", last_addr, 32'h1400);
    check("dirty_rdata", rd, 32'h01400000);
    finish_access();
    access(1, 0, 32'h1004, 4'h0, 0);
    check("reload_stalls", ns, 2);
    check("reload_rdata", rd, 32'hDEADABEF);
    finish_access();

    cpu_addr = 32'h1800; cpu_re = 1'b1; #1;
    check("pre_rst_stall", stall, 1);
    @(posedge clk); #1;
    check("refill_1800", mem_addr, 32'h1800);
    rst_n = 1'b0; cpu_re = 1'b0; #1;
    check("mid_rst_stall", stall, 0);
    check("mid_rst_wr_en", mem_wr_en, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    access(1, 0, 32'h1000, 4'h0, 0);
    check("post_rst_stalls", ns, 2);
    check("post_rst_rdata", rd, 32'h11223344);
    finish_access();

    access(1, 1, 32'h1008, 4'hF, 32'hCAFEF00D);
    check("rw_stalls", ns, 0);
    check("rw_wr_en", mem_wr_en, 0);
    finish_access();
    access(1, 0, 32'h1408, 4'h0, 0);
    check("rw_dirty_stalls", ns, 3);
    check("rw_wb_addr", wb_addr, 32'h1000);
    check("rw_wb_word2", wb_data[95:64], 32'h0DF0FECA);
    check("rw_evict_rdata", rd, 32'h01400002);
    finish_access();
    access(1, 0, 32'h1008, 4'h0, 0);
    check("rw_reload_stalls", ns, 2);
    check("rw_reload_rdata", rd, 32'hCAFEF00D);
    finish_access();
    access(0, 0, 32'h2000, 4'h0, 0);
    check("idle_no_req", stall, 0);
    finish_access();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
